// File: rtl/bist_sequencer.sv
// bist_sequencer: one LBIST session (INIT, RUN, FLUSH, CMP, DONE); optional watchdog under BIST_WATCHDOG_EN.
// Latency: done rises NUM_PATTERNS+FLUSH_CYC+2 cycles after INIT; no backpressure, abort cancels in any cycle.
module bist_sequencer #(
  parameter int BITS         = 8,
  parameter int SIG_BITS     = 16,
  parameter int NUM_PATTERNS = 200,
  parameter int FLUSH_CYC    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [BITS-1:0]     pat_count,
  input  logic [SIG_BITS-1:0] misr_sig,
  input  logic [SIG_BITS-1:0] golden_sig,
  output logic                cnt_rst,
  output logic                cnt_inc,
  output logic                lfsr_load,
  output logic                lfsr_en,
  output logic                misr_clr,
  output logic                misr_en,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] CMP   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam int              FW         = $clog2(FLUSH_CYC + 1);
  localparam logic [BITS-1:0] LAST_PAT   = BITS'(NUM_PATTERNS - 1);
  localparam logic [FW-1:0]   FLUSH_LOAD = FW'(FLUSH_CYC - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [FW-1:0] flush_cnt;
  logic          wd_fire;
  logic          pass_nxt;
  logic          timeout_nxt;

`ifdef BIST_WATCHDOG_EN
  localparam int            WW      = $clog2(NUM_PATTERNS + 5);
  localparam logic [WW-1:0] WD_LAST = WW'(NUM_PATTERNS + 3);

  logic [WW-1:0] wd_cnt;

  // Fires on the RUN cycle that brings the count to NUM_PATTERNS+4.
  always_ff @(posedge clk) begin
    if (rst || state == INIT)
      wd_cnt <= '0;
    else if (state == RUN)
      wd_cnt <= wd_cnt + WW'(1);
  end

  assign wd_fire = (state == RUN) && (wd_cnt == WD_LAST);
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = INIT;
      INIT:  state_nxt = RUN;
      RUN: begin
        if (pat_count == LAST_PAT)
          state_nxt = FLUSH;
        else if (wd_fire)
          state_nxt = DONE;
      end
      FLUSH: if (flush_cnt == '0) state_nxt = CMP;
      CMP:   state_nxt = DONE;
      DONE:  if (start) state_nxt = INIT;
      default: state_nxt = IDLE;
    endcase
    if (abort)
      state_nxt = IDLE;
  end

  // Result flags only survive while the FSM stays in DONE.
  always_comb begin
    pass_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    if (state_nxt == DONE) begin
      if (state == CMP) begin
        pass_nxt = (misr_sig == golden_sig);
      end else if (state == DONE) begin
        pass_nxt    = pass;
        timeout_nxt = timeout;
      end else begin
        timeout_nxt = wd_fire;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != FLUSH)
      flush_cnt <= FLUSH_LOAD;
    else if (flush_cnt != '0)
      flush_cnt <= flush_cnt - FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_rst   <= 1'b0;
      cnt_inc   <= 1'b0;
      lfsr_load <= 1'b0;
      lfsr_en   <= 1'b0;
      misr_clr  <= 1'b0;
      misr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt_rst   <= (state_nxt == INIT);
      cnt_inc   <= (state_nxt == RUN);
      lfsr_load <= (state_nxt == INIT);
      lfsr_en   <= (state_nxt == RUN);
      misr_clr  <= (state_nxt == INIT);
      misr_en   <= (state_nxt == RUN) || (state_nxt == FLUSH);
      busy      <= (state_nxt inside {INIT, RUN, FLUSH, CMP});
      done      <= (state_nxt == DONE);
      pass      <= pass_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: counter/LFSR/MISR datapath plus a signature model built from pattern lists.
module tb_bist_sequencer;

  localparam int BITS     = 8;
  localparam int SIG_BITS = 16;
  localparam int NP       = 16;
  localparam int FC       = 2;

  localparam logic [9:0] INIT_OUTS = 10'b1010101000;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [BITS-1:0]     pat_count;
  logic [SIG_BITS-1:0] misr_sig;
  logic [SIG_BITS-1:0] golden_sig = '0;
  logic cnt_rst, cnt_inc, lfsr_load, lfsr_en, misr_clr, misr_en;
  logic busy, done, pass, timeout;

  int total = 0;
  int bad   = 0;

  bist_sequencer #(
    .BITS(BITS), .SIG_BITS(SIG_BITS), .NUM_PATTERNS(NP), .FLUSH_CYC(FC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pat_count(pat_count), .misr_sig(misr_sig), .golden_sig(golden_sig),
    .cnt_rst(cnt_rst), .cnt_inc(cnt_inc), .lfsr_load(lfsr_load), .lfsr_en(lfsr_en),
    .misr_clr(misr_clr), .misr_en(misr_en), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] cut_fn(input logic [15:0] c);
    return {c[7:0], c[15:8]} ^ 16'h5a3c;
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] d);
    return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ d;
  endfunction

  // Expected signature: NP patterns from the seed, seen by the MISR FC cycles late.
  function automatic logic [15:0] ref_sig(input logic [15:0] s);
    logic [15:0] pats[$];
    logic [15:0] p;
    logic [15:0] m;
    p = s;
    for (int i = 0; i < NP; i++) begin
      pats.push_back(p);
      p = lfsr_step(p);
    end
    m = '0;
    for (int k = 0; k < NP + FC; k++)
      m = misr_step(m, (k >= FC) ? cut_fn(pats[k - FC]) : 16'h0);
    return m;
  endfunction

  logic [BITS-1:0] cnt   = '0;
  logic [15:0]     lfsr  = '0;
  logic [15:0]     misr  = '0;
  logic [15:0]     pipe0 = '0;
  logic [15:0]     pipe1 = '0;
  logic [15:0]     seed  = 16'h0001;
  logic            stuck = 1'b0;

  always @(posedge clk) begin
    if (cnt_rst) cnt <= '0;
    else if (cnt_inc) cnt <= cnt + 1'b1;
    if (lfsr_load) lfsr <= seed;
    else if (lfsr_en) lfsr <= lfsr_step(lfsr);
    if (misr_clr) begin
      misr  <= '0;
      pipe0 <= '0;
      pipe1 <= '0;
    end else begin
      pipe0 <= lfsr_en ? cut_fn(lfsr) : 16'h0;
      pipe1 <= pipe0;
      if (misr_en) misr <= misr_step(misr, pipe1);
    end
  end

  assign pat_count = stuck ? BITS'(3) : cnt;
  assign misr_sig  = misr;

  logic [9:0] outs;
  assign outs = {cnt_rst, cnt_inc, lfsr_load, lfsr_en, misr_clr, misr_en, busy, done, pass, timeout};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts from the INIT sample; lat = cycles from INIT to first done (-1 if the budget expires).
  task automatic run_to_done(input int limit, output int lat, output int incs,
                             output int inits, output bit excl_ok);
    lat = -1; incs = 0; inits = 0; excl_ok = 1'b1;
    for (int t = 0; t <= limit; t++) begin
      if (cnt_inc) incs++;
      if (cnt_rst) inits++;
      if ((cnt_rst && cnt_inc) || (lfsr_load && lfsr_en) || (misr_clr && misr_en))
        excl_ok = 1'b0;
      if (done) begin
        lat = t;
        break;
      end
      step();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int  lat, incs, inits;
    bit  excl_ok;
    bit  flip;
    int  bitpos;
    int  gap;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("reset_outs", outs, 10'h0);
    rst = 1'b0;
    step();
    chk("idle_outs", outs, 10'h0);

    // Full session with matching golden
    seed = 16'hACE1;
    golden_sig = ref_sig(seed);
    pulse_start();
    chk("init_outs", outs, INIT_OUTS);
    run_to_done(60, lat, incs, inits, excl_ok);
    chk("done_latency", lat, NP + FC + 2);
    chk("cnt_inc_cycles", incs, NP);
    chk("exclusive_ctrl", excl_ok, 1);
    chk("sig_model", misr_sig, golden_sig);
    chk("pass_match", pass, 1);
    chk("timeout_clean", timeout, 0);
    chk("busy_in_done", busy, 0);
    chk("counter_final", cnt, NP);
    step(); step(); step();
    chk("done_hold", done, 1);
    chk("pass_hold", pass, 1);

    // Golden bit 0 flipped
    seed = 16'($urandom_range(1, 65535));
    golden_sig = ref_sig(seed) ^ 16'h0001;
    pulse_start();
    run_to_done(60, lat, incs, inits, excl_ok);
    chk("bad_latency", lat, NP + FC + 2);
    chk("bad_pass", pass, 0);
    chk("bad_timeout", timeout, 0);

    // Reset for 2 cycles mid-RUN, then a clean session
    seed = 16'($urandom_range(1, 65535));
    golden_sig = ref_sig(seed);
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    chk("midrun_busy", busy, 1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_mid_outs", outs, 10'h0);
    step();
    chk("rst_idle_stays", outs, 10'h0);
    pulse_start();
    chk("rst_reinit", outs, INIT_OUTS);
    run_to_done(60, lat, incs, inits, excl_ok);
    chk("rst_re_latency", lat, NP + FC + 2);
    chk("rst_re_pass", pass, 1);

    // Abort during the fifth RUN cycle
    pulse_start();
    for (int i = 0; i < 5; i++) step();
    chk("abort_pre_count", pat_count, 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_outs", outs, 10'h0);
    chk("abort_counter", cnt, 5);
    step(); step();
    chk("abort_counter_hold", cnt, 5);

    // Start held high across two sessions
    seed = 16'($urandom_range(1, 65535));
    golden_sig = ref_sig(seed);
    start = 1'b1;
    step();
    run_to_done(60, lat, incs, inits, excl_ok);
    chk("held_lat1", lat, NP + FC + 2);
    chk("held_inits1", inits, 1);
    chk("held_pass1", pass, 1);
    step();
    chk("held_reinit", outs, INIT_OUTS);
    run_to_done(60, lat, incs, inits, excl_ok);
    chk("held_lat2", lat, NP + FC + 2);
    chk("held_inits2", inits, 1);
    start = 1'b0;
    step();
    chk("held_done_hold", done, 1);

    // Stuck pattern counter
    stuck = 1'b1;
    pulse_start();
    for (int i = 0; i < 20; i++) step();
`ifdef BIST_WATCHDOG_EN
    chk("wd_not_yet", done, 0);
    step();
    chk("wd_done", done, 1);
    chk("wd_pass", pass, 0);
    chk("wd_timeout", timeout, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("wd_abort_clear", outs, 10'h0);
`else
    step();
    chk("stuck_busy", busy, 1);
    chk("stuck_cnt_inc", cnt_inc, 1);
    chk("stuck_done", done, 0);
    chk("stuck_timeout", timeout, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("stuck_abort", outs, 10'h0);
`endif
    stuck = 1'b0;

    // Randomized sessions
    for (int i = 0; i < 5; i++) begin
      seed   = 16'($urandom_range(1, 65535));
      flip   = 1'($urandom_range(0, 1));
      bitpos = int'($urandom_range(0, 15));
      golden_sig = ref_sig(seed) ^ (flip ? (16'h0001 << bitpos) : 16'h0000);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      pulse_start();
      run_to_done(60, lat, incs, inits, excl_ok);
      chk("rand_latency", lat, NP + FC + 2);
      chk("rand_incs", incs, NP);
      chk("rand_excl", excl_ok, 1);
      chk("rand_pass", pass, {31'b0, ~flip});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
